dbg_halt_ctrl: RTL and testbench
================================

DBG_HALT_CTRL -- requirements
Module: dbg_halt_ctrl

Interface
REQ-001 Parameter XLEN, default 64, width of PC and breakpoint addresses.
REQ-002 Parameter NUM_BP, default 4, number of hardware PC breakpoints (1..16).
REQ-003 Parameter DEB_CYCLES, default 16, cycles a key level must be stable before it is accepted.
REQ-004 Port clk  input  1  the only clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port pc  input  XLEN  PC of the instruction currently presented to the core.
REQ-007 Port is_debug  input  1  current instruction decodes as ebreak.
REQ-008 Port continue_key  input  1  raw, asynchronous resume button.
REQ-009 Port step_key  input  1  raw, asynchronous single-step button.
REQ-010 Port bp_wr_en  input  1  breakpoint-table write strobe.
REQ-011 Port bp_idx  input  4  breakpoint slot to write.
REQ-012 Port bp_addr  input  XLEN  breakpoint PC to store.
REQ-013 Port bp_valid  input  1  enable bit stored with bp_addr.
REQ-014 Port stall  output  1  holds the PC when high.
REQ-015 Port halted  output  1  controller is in HALTED.
REQ-016 Port halt_cause  output  2  0 none, 1 ebreak, 2 breakpoint, 3 step.
REQ-017 Port halt_pc  output  XLEN  PC captured at the last halt.
REQ-018 Port halt_count  output  16  number of halts since reset, saturating.

Function
REQ-019 The FSM SHALL have three states: RUN, HALTED and SKIP (one-cycle release).
REQ-020 hit SHALL be is_debug OR (pc equals any valid slot address); this is a combinational compare.
REQ-021 In RUN with hit high, stall SHALL be high in that same cycle, so the PC never advances past the hit; the next state is HALTED.
REQ-022 On entry to HALTED: halt_pc <= pc; halt_cause <= 1 if is_debug, else 2 (ebreak has priority); halt_count increments, saturating at 16'hFFFF.
REQ-023 In HALTED, stall SHALL be high, and halted SHALL be high.
REQ-024 A debounced continue_key rising edge in HALTED SHALL move the FSM to SKIP; the FSM SHALL then go to RUN.
REQ-025 A debounced step_key rising edge in HALTED SHALL move the FSM to SKIP; the FSM SHALL then go to HALTED, with halt_cause=3 and halt_pc = the new pc.
REQ-026 In SKIP, stall SHALL be low for exactly one cycle, and hit SHALL be ignored, so a resume from a breakpoint or ebreak executes it once.
REQ-027 If continue and step edges occur in the same cycle, step SHALL win.
REQ-028 Key edges in RUN or SKIP SHALL be discarded.
REQ-029 Each key path SHALL pass through a 2-flop synchroniser, then a stability counter of DEB_CYCLES cycles.
REQ-030 Each key path SHALL produce a one-cycle pulse on an accepted 0->1 transition.
REQ-031 A write with bp_wr_en=1 and bp_idx < NUM_BP SHALL update the slot; the write is visible to hit from the next cycle.
REQ-032 A write with bp_idx >= NUM_BP SHALL be ignored.
REQ-033 Breakpoint writes SHALL be accepted in every state.
REQ-034 In RUN with no hit, stall SHALL be low.
REQ-035 In RUN, halt_cause and halt_pc SHALL hold their last values.

Reset
REQ-036 On rst, the state SHALL be RUN, stall=0, halted=0, halt_cause=0, halt_pc=0 and halt_count=0.
REQ-037 On rst, all breakpoint valid bits SHALL be 0 and the debounce counters and synchronisers SHALL be 0.
REQ-038 An rst during HALTED or SKIP SHALL take effect on that edge, with no pending step or continue surviving it.

Structure
REQ-039 Package dbg_pkg SHALL hold the state encoding, the halt-cause constants (CAUSE_NONE/EBREAK/BP/STEP) and the halt_count width.
REQ-040 Sub-module key_debounce SHALL be instantiated twice, once per key; it contains the synchroniser, the counter and the edge pulse, and is parameterised by DEB_CYCLES.
REQ-041 The breakpoint compare SHALL be a generate loop over NUM_BP with an OR reduction.

Verification
REQ-042 With is_debug=1 at pc=0x40 in RUN: stall=1 in the same cycle, then halted=1, halt_cause=1, halt_pc=0x40, halt_count=1.
REQ-043 Program slot 2 to 0x80 with valid=1, and present pc=0x80 one cycle later: stall=1 and halt_cause=2, with pc held at 0x80.
REQ-044 While halted at 0x80, hold continue_key high for DEB_CYCLES+3 cycles: one SKIP cycle with stall=0, pc advances to 0x84, and the FSM runs with no re-halt at 0x80.
REQ-045 While halted, press step_key: exactly one cycle with stall=0, then halted=1, halt_cause=3, halt_pc=0x84.
REQ-046 Key glitch shorter than DEB_CYCLES while halted: no state change. Simultaneous key edges: step behaviour.
REQ-047 Assert rst while HALTED with slot 0 valid: all outputs at reset values, and pc equal to the old slot address does not halt.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared state encoding, halt-cause codes and counter width for the debug
// halt controller.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_SKIP   = 2'd2
  } dbg_state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK = 2'd1;
  localparam logic [1:0] CAUSE_BP     = 2'd2;
  localparam logic [1:0] CAUSE_STEP   = 2'd3;

  localparam int unsigned HCNT_W = 16;

  function automatic logic [HCNT_W-1:0] sat_inc(input logic [HCNT_W-1:0] v);
    return (v == '1) ? v : v + HCNT_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw key conditioning: 2-flop synchroniser, stability counter and a
// one-cycle pulse on an accepted 0->1 transition.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q, stable_q, pulse_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // A new level is taken once it has differed from the accepted one for
  // DEB_CYCLES consecutive samples.
  assign accept = (sync2_q != stable_q) && (cnt_q == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      pulse_q <= accept & sync2_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug halt controller: stalls the core on ebreak or a PC breakpoint and
// releases it for one cycle on a debounced continue or step key.
module dbg_halt_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NUM_BP     = 4,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  input  logic              is_debug,
  input  logic              continue_key,
  input  logic              step_key,
  input  logic              bp_wr_en,
  input  logic [3:0]        bp_idx,
  input  logic [XLEN-1:0]   bp_addr,
  input  logic              bp_valid,
  output logic              stall,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [XLEN-1:0]   halt_pc,
  output logic [HCNT_W-1:0] halt_count
);

  dbg_state_e        state_q, state_d;
  logic              step_q, step_d;
  logic              pc_pend_q, pc_pend_d;
  logic [1:0]        cause_q, cause_d;
  logic [XLEN-1:0]   hpc_q, hpc_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  logic              cont_pulse, step_pulse;
  logic [XLEN-1:0]   bp_addr_q [NUM_BP];
  logic              bp_valid_q [NUM_BP];
  logic [NUM_BP-1:0] bp_match;
  logic              hit;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cont_deb (
    .clk(clk), .rst(rst), .key_i(continue_key), .pulse_o(cont_pulse)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk(clk), .rst(rst), .key_i(step_key), .pulse_o(step_pulse)
  );

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (rst) begin
        bp_valid_q[i] <= 1'b0;
        bp_addr_q[i]  <= '0;
      end else if (bp_wr_en && (bp_idx == 4'(i))) begin
        bp_valid_q[i] <= bp_valid;
        bp_addr_q[i]  <= bp_addr;
      end
    end
  end

  for (genvar g = 0; g < NUM_BP; g++) begin : g_bp_cmp
    assign bp_match[g] = bp_valid_q[g] && (bp_addr_q[g] == pc);
  end

  assign hit = is_debug | (|bp_match);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pc_pend_d = 1'b0;
    cause_d   = cause_q;
    hpc_d     = hpc_q;
    hcnt_d    = hcnt_q;
    stall     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (hit) begin
          stall   = 1'b1;
          state_d = ST_HALTED;
          cause_d = is_debug ? CAUSE_EBREAK : CAUSE_BP;
          hpc_d   = pc;
          hcnt_d  = sat_inc(hcnt_q);
        end
      end
      ST_HALTED: begin
        stall = 1'b1;
        if (pc_pend_q) hpc_d = pc;
        if (step_pulse) begin
          state_d = ST_SKIP;
          step_d  = 1'b1;
        end else if (cont_pulse) begin
          state_d = ST_SKIP;
          step_d  = 1'b0;
        end
      end
      ST_SKIP: begin
        // After a step the core has not yet presented the new PC at this
        // edge, so it is taken in the first HALTED cycle instead.
        if (step_q) begin
          state_d   = ST_HALTED;
          cause_d   = CAUSE_STEP;
          hcnt_d    = sat_inc(hcnt_q);
          pc_pend_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      step_q    <= 1'b0;
      pc_pend_q <= 1'b0;
      cause_q   <= CAUSE_NONE;
      hpc_q     <= '0;
      hcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      pc_pend_q <= pc_pend_d;
      cause_q   <= cause_d;
      hpc_q     <= hpc_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = cause_q;
  assign halt_pc    = pc_pend_q ? pc : hpc_q;
  assign halt_count = hcnt_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Bench for dbg_halt_ctrl: directed halt/resume scenarios followed by a
// randomized run checked against a behavioural model of the debug rules.
module tb_dbg_halt_ctrl;

  localparam int XLEN   = 64;
  localparam int NUM_BP = 4;
  localparam int DEB    = 8;

  logic            clk = 1'b0;
  logic            rst, is_debug, continue_key, step_key, bp_wr_en, bp_valid;
  logic [XLEN-1:0] pc, bp_addr, halt_pc;
  logic [3:0]      bp_idx;
  logic            stall, halted;
  logic [1:0]      halt_cause;
  logic [15:0]     halt_count;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0] m_addr [NUM_BP];
  bit              m_valid [NUM_BP];
  bit              m_halted;
  logic [1:0]      m_cause;
  logic [XLEN-1:0] m_hpc;
  int              m_count;

  dbg_halt_ctrl #(.XLEN(XLEN), .NUM_BP(NUM_BP), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .pc(pc), .is_debug(is_debug),
    .continue_key(continue_key), .step_key(step_key),
    .bp_wr_en(bp_wr_en), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .stall(stall), .halted(halted), .halt_cause(halt_cause),
    .halt_pc(halt_pc), .halt_count(halt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [XLEN-1:0] p, input logic dbg);
    bit h = (dbg === 1'b1);
    for (int i = 0; i < NUM_BP; i++)
      if (m_valid[i] && m_addr[i] == p) h = 1;
    return h;
  endfunction

  task automatic model_write();
    if (bp_wr_en && int'(bp_idx) < NUM_BP) begin
      m_addr[bp_idx]  = bp_addr;
      m_valid[bp_idx] = bp_valid;
    end
    bp_wr_en = 1'b0;
  endtask

  task automatic run_step();
    bit exp = m_hit(pc, is_debug);
    @(negedge clk);
    check("run_stall", 64'(stall), 64'(exp));
    check("run_halted", 64'(halted), 64'(0));
    if (!exp) begin
      check("run_cause_hold", 64'(halt_cause), 64'(m_cause));
      check("run_pc_hold", 64'(halt_pc), 64'(m_hpc));
      check("run_count", 64'(halt_count), 64'(m_count));
    end
    @(posedge clk); #1;
    if (exp) begin
      m_halted = 1;
      m_hpc    = pc;
      m_cause  = (is_debug === 1'b1) ? 2'd1 : 2'd2;
      if (m_count < 16'hFFFF) m_count++;
    end else begin
      pc = pc + 4;
    end
    model_write();
  endtask

  task automatic halted_step();
    @(negedge clk);
    check("halt_stall", 64'(stall), 64'(1));
    check("halted", 64'(halted), 64'(1));
    check("halt_cause", 64'(halt_cause), 64'(m_cause));
    check("halt_pc", 64'(halt_pc), 64'(m_hpc));
    check("halt_count", 64'(halt_count), 64'(m_count));
    @(posedge clk); #1;
    model_write();
  endtask

  task automatic press_keys(input bit cont, input bit stp, input int hold, input bit expect_go);
    int low_at = -1;
    for (int i = 0; i < DEB + 6; i++) halted_step();
    continue_key = cont;
    step_key     = stp;
    for (int c = 0; c < DEB + 12; c++) begin
      if (c == hold) begin continue_key = 1'b0; step_key = 1'b0; end
      @(negedge clk);
      if (stall === 1'b0) low_at = c;
      @(posedge clk); #1;
      if (low_at >= 0) begin
        pc = pc + 4;
        break;
      end
    end
    continue_key = 1'b0;
    step_key     = 1'b0;
    if (expect_go) begin
      check("release_window", 64'(low_at >= DEB && low_at <= DEB + 6), 64'(1));
      is_debug = 1'b0;
      if (stp) begin
        m_cause = 2'd3;
        m_hpc   = pc;
        if (m_count < 16'hFFFF) m_count++;
      end else begin
        m_halted = 0;
      end
    end else begin
      check("glitch_ignored", 64'(low_at), 64'(-1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m_halted = 0; m_cause = 2'd0; m_hpc = '0; m_count = 0;
    for (int i = 0; i < NUM_BP; i++) m_valid[i] = 0;
    bp_wr_en = 1'b0;
  endtask

  task automatic bp_set(input int idx, input logic [XLEN-1:0] a, input logic v);
    bp_wr_en = 1'b1;
    bp_idx   = 4'(idx);
    bp_addr  = a;
    bp_valid = v;
  endtask

  initial begin
    int r;
    is_debug = 0; continue_key = 0; step_key = 0;
    bp_wr_en = 0; bp_idx = '0; bp_addr = '0; bp_valid = 0; pc = '0;
    for (int i = 0; i < NUM_BP; i++) begin m_addr[i] = '0; m_valid[i] = 0; end

    do_reset();
    run_step();

    pc = 64'h40; is_debug = 1'b1;
    run_step();
    halted_step();
    press_keys(1, 0, DEB + 3, 1);

    pc = 64'h7c;
    bp_set(2, 64'h80, 1'b1);
    run_step();
    run_step();
    bp_set(3, 64'h90, 1'b1);
    halted_step();
    press_keys(1, 0, DEB + 3, 1);
    bp_set(9, 64'h88, 1'b1);
    run_step();
    run_step();
    run_step();
    run_step();
    halted_step();
    press_keys(1, 0, DEB + 3, 1);
    run_step();

    pc = 64'h80;
    run_step();
    press_keys(0, 1, DEB + 3, 1);
    halted_step();
    press_keys(1, 0, DEB - 3, 0);
    press_keys(0, 1, DEB - 3, 0);
    halted_step();
    press_keys(1, 1, DEB + 3, 1);
    halted_step();
    press_keys(1, 0, DEB + 3, 1);
    run_step();

    for (int n = 0; n < 200; n++) begin
      if (pc < 64'h100 || pc >= 64'h140) pc = 64'h100;
      is_debug = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        bp_set($urandom_range(0, 15), 64'h100 + 64'($urandom_range(0, 15)) * 4,
               1'($urandom_range(0, 1)));
      run_step();
      for (int k = 0; k < 4 && m_halted; k++) begin
        r = (k == 3) ? 0 : $urandom_range(0, 2);
        press_keys(r != 1, r != 0, DEB + 3, 1);
      end
    end

    is_debug = 1'b0;
    pc = 64'h2fc;
    bp_set(0, 64'h300, 1'b1);
    run_step();
    run_step();
    halted_step();
    step_key = 1'b1;
    halted_step();
    halted_step();
    do_reset();
    step_key = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 64'h300;
      run_step();
    end
    for (int i = 0; i < DEB + 4; i++) run_step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
